// File: rtl/coproc_muldiv_pkg.sv
// coproc_pkg: shared opcodes, state encoding and command/result field positions
package coproc_pkg;
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  localparam logic [23:0] ERR_WORD = 24'h800000;
  localparam int OP_HI = 23;
  localparam int OP_LO = 22;
  localparam int A_HI = 21;
  localparam int A_LO = 11;
  localparam int B_HI = 10;
  localparam int B_LO = 0;
endpackage

// File: rtl/coproc_muldiv_if.sv
// coproc_muldiv_if: command/result handshake between bridge and muldiv engine
interface coproc_muldiv_if;
  logic mstart;
  logic [23:0] min;
  logic mrdy;
  logic [23:0] mout;
  logic busy;
  modport master(output mstart, min, input mrdy, mout, busy);
  modport slave(input mstart, min, output mrdy, mout, busy);
endinterface

// File: rtl/coproc_muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring divide iteration
module muldiv_step #(
  parameter int W = 11,
  parameter int CW = 4
) (
  input  logic             div,
  input  logic [CW-1:0]    cnt,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2*W-1:0]   acc,
  input  logic [W-1:0]     rem,
  output logic [2*W-1:0]   acc_n,
  output logic [W-1:0]     rem_n
);
  logic [CW-1:0] idx;
  logic [W:0] trial;
  logic ge;
  // Multiply walks B from its LSB; divide brings in A from its MSB and shifts quotient bits into acc
  always_comb begin
    idx = CW'(W - 1) - cnt;
    trial = {rem, a[cnt]};
    ge = trial >= {1'b0, b};
    acc_n = div ? {acc[2*W-2:0], ge} : acc + (b[idx] ? {{W{1'b0}}, a} << idx : '0);
    rem_n = ge ? W'(trial - {1'b0, b}) : trial[W-1:0];
  end
endmodule

// File: rtl/coproc_muldiv.sv
// coproc_muldiv: iterative 11-bit unsigned multiply/divide engine behind the bus bridge
module coproc_muldiv
  import coproc_pkg::*;
#(
  parameter int W = 11
) (
  input logic clk,
  input logic rst,
  coproc_muldiv_if.slave bus
);
  localparam int CW = $clog2(W);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic div, div_n, accept, err;
  logic [1:0] op;
  logic [W-1:0] a, a_n, b, b_n, rem, rem_n, srem, ia, ib;
  logic [2*W-1:0] acc, acc_n, sacc;
  logic [23:0] mout_n;
  muldiv_step #(.W(W), .CW(CW)) u_step (
    .div(div), .cnt(cnt), .a(a), .b(b), .acc(acc), .rem(rem), .acc_n(sacc), .rem_n(srem)
  );
  // State, datapath and output registers; outputs are derived from next-state so they come straight off flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      div <= 1'b0;
      a <= '0;
      b <= '0;
      acc <= '0;
      rem <= '0;
      bus.mrdy <= 1'b0;
      bus.mout <= '0;
      bus.busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      div <= div_n;
      a <= a_n;
      b <= b_n;
      acc <= acc_n;
      rem <= rem_n;
      bus.mrdy <= state_n == ST_DONE;
      bus.mout <= mout_n;
      bus.busy <= state_n != ST_IDLE;
    end
  end
  // Accept commands in IDLE or DONE, iterate in RUN, and capture the result on the last iteration
  always_comb begin
    op = bus.min[OP_HI:OP_LO];
    ia = bus.min[A_HI:A_LO];
    ib = bus.min[B_HI:B_LO];
    accept = bus.mstart && state != ST_RUN;
    err = op[1] || (op == OP_DIV && ib == '0);
    state_n = state == ST_DONE ? ST_IDLE : state;
    cnt_n = cnt;
    div_n = div;
    a_n = a;
    b_n = b;
    acc_n = acc;
    rem_n = rem;
    mout_n = bus.mout;
    if (accept && err) begin
      state_n = ST_DONE;
      mout_n = op[1] ? ERR_WORD : {2'b10, {W{1'b1}}, ia};
    end else if (accept) begin
      state_n = ST_RUN;
      cnt_n = CW'(W - 1);
      div_n = op[0];
      a_n = ia;
      b_n = ib;
      acc_n = '0;
      rem_n = '0;
    end else if (state == ST_RUN) begin
      acc_n = sacc;
      rem_n = srem;
      if (cnt == '0) begin
        state_n = ST_DONE;
        mout_n = div ? {2'b00, sacc[W-1:0], srem} : {2'b00, sacc};
      end else begin
        cnt_n = cnt - 1'b1;
      end
    end
  end
endmodule
